// File: rtl/banked_data_memory_if.sv
// Load/store bus shared by all ports of the banked data memory.
// Per-port fields are packed side by side: port i owns Control[2i+1:2i],
// DataAddr[i*ADDR_WIDTH +: ADDR_WIDTH], DataIn/DataOut[i*DATA_WIDTH +: DATA_WIDTH].
interface banked_data_memory_if #(
  parameter int NUM_PORTS  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
);
  logic [2*NUM_PORTS-1:0]          Control;
  logic [ADDR_WIDTH*NUM_PORTS-1:0] DataAddr;
  logic [DATA_WIDTH*NUM_PORTS-1:0] DataIn;
  logic [NUM_PORTS-1:0]            Ready;
  logic [DATA_WIDTH*NUM_PORTS-1:0] DataOut;
  logic [NUM_PORTS-1:0]            DataValid;

  modport master (
    output Control, DataAddr, DataIn,
    input  Ready, DataOut, DataValid
  );

  modport slave (
    input  Control, DataAddr, DataIn,
    output Ready, DataOut, DataValid
  );
endinterface

// File: rtl/banked_data_memory.sv
// Multi-port data memory split into single-access banks. Each bank runs its
// own round-robin arbiter over the ports addressing it; Ready is the
// combinational grant, reads return registered data one cycle later.
// Bank select is the low address bits, so consecutive words land in
// different banks.
module banked_data_memory #(
  parameter int NUM_PORTS  = 16,
  parameter int NUM_BANKS  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                 Clock_i,
  input  logic                 Reset_i,
  banked_data_memory_if.slave  bus
);
  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;
  localparam int RW        = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int ROWS      = (1 << ADDR_WIDTH) / NUM_BANKS;
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  is_wr;
  logic [BW-1:0]         port_bank  [NUM_PORTS];
  logic [RW-1:0]         port_row   [NUM_PORTS];
  logic [DATA_WIDTH-1:0] port_wdata [NUM_PORTS];
  logic [NUM_PORTS-1:0]  ready;

  logic [PW-1:0]         ptr_q   [NUM_BANKS];
  logic [PW-1:0]         ptr_d   [NUM_BANKS];
  logic [DATA_WIDTH-1:0] dout_q  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  valid_q;
  logic [DATA_WIDTH-1:0] mem_q   [NUM_BANKS][ROWS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    assign addr          = bus.DataAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
    // op 2 = read, 3 = write; 0/1 are idle, so the upper bit alone is the request
    assign req[i]        = bus.Control[2*i+1];
    assign is_wr[i]      = bus.Control[2*i+1] & bus.Control[2*i];
    assign port_bank[i]  = BW'(addr % NUM_BANKS);
    assign port_row[i]   = RW'(addr / NUM_BANKS);
    assign port_wdata[i] = bus.DataIn[i*DATA_WIDTH +: DATA_WIDTH];
    assign bus.DataOut[i*DATA_WIDTH +: DATA_WIDTH] = dout_q[i];
  end

  assign bus.Ready     = ready;
  assign bus.DataValid = valid_q;

  // Per-bank round-robin: first requester at or after the bank pointer wins;
  // the pointer moves just past the winner so it goes to the back of the line.
  always_comb begin : arb
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    ready = '0;
    ptr_d = ptr_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      found = 1'b0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = int'(ptr_q[b]) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (!found && req[idx] && (port_bank[idx] == BW'(b))) begin
          found      = 1'b1;
          ready[idx] = 1'b1;
          ptr_d[b]   = PW'((idx + 1) % NUM_PORTS);
        end
      end
    end
    // nothing is accepted while reset is held, so pending requests just drop
    if (Reset_i) ready = '0;
  end

  // RAM write port per bank; no reset so contents survive a reset pulse.
  always_ff @(posedge Clock_i) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (ready[i] && is_wr[i]) mem_q[port_bank[i]][port_row[i]] <= port_wdata[i];
    end
  end

  // Read data capture, DataValid pulse and arbitration pointers.
  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) dout_q[i] <= '0;
      for (int b = 0; b < NUM_BANKS; b++) ptr_q[b] <= '0;
    end else begin
      ptr_q <= ptr_d;
      for (int i = 0; i < NUM_PORTS; i++) begin
        valid_q[i] <= ready[i] & ~is_wr[i];
        if (ready[i] && !is_wr[i]) dout_q[i] <= mem_q[port_bank[i]][port_row[i]];
      end
    end
  end
endmodule

// File: tb/tb_banked_data_memory.sv
// Bench for banked_data_memory: directed scenarios with literal expectations
// followed by randomized traffic, all checked against a flat word-addressed
// memory model with per-bank round-robin pointers.
module tb_banked_data_memory;
  localparam int NP = 16;
  localparam int NB = 4;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banked_data_memory_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  banked_data_memory #(
    .NUM_PORTS(NP), .NUM_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .Clock_i(clk),
    .Reset_i(rst),
    .bus(bus.slave)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0]  mem_m   [256];
  bit             known_m [256];
  int             ptr_m   [NB];
  logic [DW-1:0]  dout_m  [NP];
  bit             dknown  [NP];
  logic [NP-1:0]  valid_m = '0;
  logic [NP-1:0]  exp_ready = '0;
  bit             live = 0;
  logic [255:0]   mask, expd;
  int             ma;

  initial begin
    for (int a = 0; a < 256; a++) known_m[a] = 0;
    for (int b = 0; b < NB; b++) ptr_m[b] = 0;
    for (int i = 0; i < NP; i++) begin dout_m[i] = '0; dknown[i] = 0; end
  end

  function automatic int op_of(int p);
    return int'(bus.Control[2*p +: 2]);
  endfunction

  function automatic int addr_of(int p);
    return int'(bus.DataAddr[p*AW +: AW]);
  endfunction

  function automatic logic [NP-1:0] model_ready();
    logic [NP-1:0] r;
    r = '0;
    if (rst) return r;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (ptr_m[b] + k) % NP;
        if (op_of(p) >= 2 && (addr_of(p) % NB) == b) begin
          r[p] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  // compare process: every negedge once the DUT has seen reset
  always @(negedge clk) begin
    if (live) begin
      exp_ready = model_ready();
      chk("ready", bus.Ready, exp_ready);
      chk("valid", bus.DataValid, valid_m);
      mask = '0;
      expd = '0;
      for (int i = 0; i < NP; i++) begin
        expd[i*DW +: DW] = dout_m[i];
        if (dknown[i]) mask[i*DW +: DW] = '1;
      end
      chk("dataout", bus.DataOut & mask, expd & mask);
    end
  end

  // model state advance at the active edge
  always @(posedge clk) begin
    if (rst) begin
      live    = 1;
      valid_m = '0;
      for (int i = 0; i < NP; i++) begin dout_m[i] = '0; dknown[i] = 1; end
      for (int b = 0; b < NB; b++) ptr_m[b] = 0;
    end else if (live) begin
      valid_m = '0;
      for (int i = 0; i < NP; i++) begin
        if (exp_ready[i]) begin
          ma = addr_of(i);
          if (op_of(i) == 3) begin
            mem_m[ma]   = bus.DataIn[i*DW +: DW];
            known_m[ma] = 1;
          end else begin
            dout_m[i]  = mem_m[ma];
            dknown[i]  = known_m[ma];
            valid_m[i] = 1'b1;
          end
          ptr_m[ma % NB] = (i + 1) % NP;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_all();
    bus.Control  = '0;
    bus.DataAddr = '0;
    bus.DataIn   = '0;
  endtask

  task automatic set_port(input int p, input logic [1:0] op, input int a, input logic [DW-1:0] d);
    bus.Control[2*p +: 2]   = op;
    bus.DataAddr[p*AW +: AW] = AW'(a);
    bus.DataIn[p*DW +: DW]   = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  logic [NP-1:0] rdy;
  logic [NP-1:0] gm;

  initial begin
    idle_all();
    rst = 1'b1;
    cyc();
    cyc();
    at_neg();
    chk("rst_ready", bus.Ready, 0);
    chk("rst_valid", bus.DataValid, 0);
    chk("rst_dout", bus.DataOut, 0);

    // write then read-back through a different port
    cyc();
    rst = 1'b0;
    set_port(0, 2'd3, 5, 16'h00AB);
    at_neg();
    chk("t1_wr_ready", bus.Ready, 16'h0001);
    cyc();
    idle_all();
    set_port(3, 2'd2, 5, 16'h0000);
    at_neg();
    chk("t1_rd_ready", bus.Ready, 16'h0008);
    cyc();
    idle_all();
    at_neg();
    chk("t1_valid", bus.DataValid, 16'h0008);
    chk("t1_dout3", bus.DataOut[3*DW +: DW], 16'h00AB);
    cyc();
    at_neg();
    chk("t1_valid_pulse", bus.DataValid, 0);

    // four distinct banks in parallel
    cyc();
    for (int p = 0; p < 4; p++) set_port(p, 2'd2, p, 16'h0000);
    at_neg();
    chk("t2_ready", bus.Ready, 16'h000F);
    cyc();
    idle_all();
    at_neg();
    chk("t2_valid", bus.DataValid, 16'h000F);

    // bank 0 contention after reset: 2, 7, 9 then pointer sits at 10
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_port(2, 2'd2, 4, 16'h0000);
    set_port(7, 2'd2, 8, 16'h0000);
    set_port(9, 2'd2, 12, 16'h0000);
    at_neg();
    chk("t3_grant_2", bus.Ready, 16'h0004);
    cyc();
    set_port(2, 2'd0, 0, 16'h0000);
    at_neg();
    chk("t3_grant_7", bus.Ready, 16'h0080);
    cyc();
    set_port(7, 2'd0, 0, 16'h0000);
    at_neg();
    chk("t3_grant_9", bus.Ready, 16'h0200);
    cyc();
    idle_all();
    set_port(3, 2'd2, 0, 16'h0000);
    set_port(11, 2'd2, 16, 16'h0000);
    at_neg();
    chk("t3_ptr_at_10", bus.Ready, 16'h0800);
    cyc();
    set_port(11, 2'd0, 0, 16'h0000);
    at_neg();
    chk("t3_wrap_to_3", bus.Ready, 16'h0008);
    cyc();
    idle_all();

    // all 16 ports write bank 1; pointer starts at 0 so turns go 0..15
    for (int i = 0; i < NP; i++) set_port(i, 2'd3, 1 + 4*i, 16'h1000 + 16'(i));
    gm = '0;
    for (int k = 0; k < NP; k++) begin
      at_neg();
      chk($sformatf("t4_turn%0d", k), bus.Ready, 256'(1) << k);
      rdy = bus.Ready;
      gm  = gm | rdy;
      cyc();
      for (int p = 0; p < NP; p++) if (rdy[p]) set_port(p, 2'd0, 0, 16'h0000);
    end
    chk("t4_each_once", gm, 16'hFFFF);
    idle_all();
    set_port(0, 2'd2, 21, 16'h0000);
    cyc();
    idle_all();
    at_neg();
    chk("t4_readback", bus.DataOut[0 +: DW], 16'h1005);

    // reset while port 5 waits on bank 2 behind port 4
    cyc();
    set_port(5, 2'd3, 6, 16'h0606);
    cyc();
    idle_all();
    set_port(4, 2'd3, 2, 16'h4444);
    set_port(5, 2'd3, 6, 16'h5555);
    at_neg();
    chk("t5_port4_first", bus.Ready, 16'h0010);
    cyc();
    set_port(4, 2'd0, 0, 16'h0000);
    rst = 1'b1;
    at_neg();
    chk("t5_rst_ready", bus.Ready, 0);
    chk("t5_rst_valid", bus.DataValid, 0);
    cyc();
    rst = 1'b0;
    idle_all();
    set_port(0, 2'd2, 21, 16'h0000);
    set_port(1, 2'd2, 6, 16'h0000);
    cyc();
    idle_all();
    set_port(1, 2'd2, 2, 16'h0000);
    at_neg();
    chk("t5_persist", bus.DataOut[0 +: DW], 16'h1005);
    chk("t5_unchanged", bus.DataOut[DW +: DW], 16'h0606);
    cyc();
    idle_all();
    at_neg();
    chk("t5_granted_wr", bus.DataOut[DW +: DW], 16'h4444);

    // op code 1 is idle: no grants, no side effects
    for (int c = 0; c < 8; c++) begin
      cyc();
      for (int p = 0; p < NP; p++)
        set_port(p, 2'd1, int'($urandom_range(0, 255)), 16'($urandom));
      at_neg();
      chk("t6_idle_ready", bus.Ready, 0);
    end
    cyc();
    idle_all();
    set_port(9, 2'd2, 6, 16'h0000);
    cyc();
    idle_all();
    at_neg();
    chk("t6_mem_kept", bus.DataOut[9*DW +: DW], 16'h0606);

    // random traffic, requests held until granted or occasionally dropped
    for (int c = 0; c < 2000; c++) begin
      at_neg();
      rdy = bus.Ready;
      cyc();
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NP; p++) begin
        if (rdy[p] || $urandom_range(0, 5) == 0)
          set_port(p, 2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 16'($urandom));
      end
    end
    cyc();
    rst = 1'b0;
    idle_all();
    cyc();
    cyc();
    at_neg();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/banked_data_memory.md
Name: banked_data_memory

Overview:
- Parametrised multi-port data memory: NUM_PORTS independent load/store ports sharing one RAM split into NUM_BANKS single-access banks.
- Bank conflicts resolved by per-bank round-robin arbitration with a per-port Ready handshake.
- Read data is registered and flagged by DataValid.
- Sits between the processing cores and the shared data store; supersedes the fixed 16-port, unarbitrated data memory.

Parameters:
- NUM_PORTS, 16, number of access ports (1..32).
- NUM_BANKS, 4, number of banks; power of two, ≤ 2^ADDR_WIDTH.
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 8, word address width; total depth = 2^ADDR_WIDTH words.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Control  input  2*NUM_PORTS  per-port op code, slice i = [2i+1:2i]; 2'd2 = read, 2'd3 = write, 2'd0/2'd1 = idle.
- DataAddr  input  ADDR_WIDTH*NUM_PORTS  per-port word address.
- DataIn  input  DATA_WIDTH*NUM_PORTS  per-port write data.
- Ready  output  NUM_PORTS  combinational per port; high = request accepted at this edge.
- DataOut  output  DATA_WIDTH*NUM_PORTS  per-port registered read data.
- DataValid  output  NUM_PORTS  per-port one-cycle pulse; DataOut updated this cycle.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high.
- Request and address decode:
  - Port i requests when its Control slice is 2 or 3.
  - Bank = DataAddr_i[log2(NUM_BANKS)-1:0]; row = the remaining upper bits.
- Arbitration (per bank, every cycle):
  - Among requesting ports mapped to a bank, grant exactly one, round-robin.
  - Search starts at that bank's pointer ptr_b and wraps from NUM_PORTS-1 to 0.
  - Ready[i] = request_i AND granted_i, purely combinational from Control, DataAddr and ptr_b.
  - Ports on different banks are granted in the same cycle; up to NUM_BANKS accesses per cycle.
- Pointer update: on any grant in bank b, ptr_b <= granted index + 1, mod NUM_PORTS. With no request, ptr_b holds.
- Handshake:
  - A requester holds Control, DataAddr and DataIn stable until it sees Ready=1 at a rising edge.
  - The access takes effect at that edge. Deasserting before Ready drops the request; no side effect.
- Write: at the granting edge, bank[row] <= DataIn_i. DataOut_i and DataValid_i are unaffected.
- Read:
  - At the granting edge, DataOut_i <= bank[row] with pre-edge contents, and DataValid_i <= 1.
  - Latency is 1 cycle from the Ready edge.
  - DataValid_i is 0 on every other cycle. DataOut_i holds its last value.
- Same-cycle conflicts:
  - Read and write to the same bank never occur together; the bank grants one.
  - A write followed by a granted read to the same address on the next edge returns the new data.
- Starvation bound: a held request is granted within NUM_PORTS cycles.
- Reset, including mid-operation:
  - DataOut = 0, DataValid = 0, all ptr_b = 0.
  - Ready = 0 for every port while Reset is high.
  - Ungranted requests are dropped; RAM contents are retained.
- Initial contents: RAM initial image is undefined except where loaded by simulation initialisation. Reset does not clear RAM.

Test Plan:
- Reset, then port 0 writes 16'h00AB to addr 5; next cycle port 3 reads addr 5. Required: Ready[0]=1 on the first edge, Ready[3]=1 on the read edge; DataOut3=16'h00AB with DataValid[3]=1 exactly one cycle after the read edge.
- Ports 0, 1, 2, 3 read addrs 0, 1, 2, 3 in one cycle (distinct banks, NUM_BANKS=4). Required: all four Ready in the same cycle; all four DataValid on the next cycle.
- Ports 2, 7, 9 hold reads to addrs 4, 8, 12 (all bank 0) after reset. Required: grants in order 2, 7, 9 on consecutive cycles; ptr_0 ends at 10.
- All 16 ports hold writes to bank 1. Required: each port granted exactly once within 16 cycles; no Ready before its turn.
- Port 5 is waiting for a bank-2 grant while port 4 holds the bank; Reset pulses for 1 cycle. Required: Ready=0 and DataValid=0 during Reset; after Reset, port 5's unaccepted request leaves memory unchanged; previously written data persists.
- Control=2'd1 on every port with varying addresses and data. Required: Ready=0, DataValid=0, memory unchanged.
